// File: rtl/led_seq.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq
//  Description : Parametrised one-hot lamp sequencer with a programmable
//                dwell time per step and forward / reverse / ping-pong / hold
//                modes. Emits one-cycle step and wrap strobes that line up
//                with the cycle in which a new light value first appears.
//
//  Parameters  : N_LEDS   number of lamps (>= 1), width of light
//                DWELL_W  width of the dwell input
//                IDX_W    derived index width, max($clog2(N_LEDS), 1)
//
//  Ports       : clk    system clock, rising edge
//                rst    synchronous active-high reset
//                en     advance enable; low freezes the sequence
//                mode   00 forward, 01 reverse, 10 ping-pong, 11 hold
//                dwell  step period minus one, in clk cycles
//                duty   (LED_SEQ_PWM_EN only) 4-bit brightness, 0..15 of 16
//                light  registered one-hot lamp drive
//                step   strobe, high with each new light value
//                wrap   strobe marking completion of a full sequence
//
//  Build macro : LED_SEQ_PWM_EN adds the duty input and PWM dimming of light.
//
//  Revision    : 1.0  initial release
// ============================================================================
module led_seq #(
    parameter int N_LEDS  = 3,
    parameter int DWELL_W = 8,
    localparam int IDX_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
`ifdef LED_SEQ_PWM_EN
    input  logic [3:0]         duty,
`endif
    output logic [N_LEDS-1:0]  light,
    output logic               step,
    output logic               wrap
);

    localparam logic [1:0]       c_MODE_FWD  = 2'b00;
    localparam logic [1:0]       c_MODE_REV  = 2'b01;
    localparam logic [1:0]       c_MODE_PP   = 2'b10;
    localparam logic [1:0]       c_MODE_HOLD = 2'b11;

    // Ping-pong direction encoding
    localparam logic             c_DIR_UP    = 1'b0;
    localparam logic             c_DIR_DOWN  = 1'b1;

    localparam logic [IDX_W-1:0] c_IDX_ZERO  = '0;
    localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(N_LEDS - 1);

    logic [DWELL_W-1:0] r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_dir;
    logic [N_LEDS-1:0]  r_light;
    logic               r_step;
    logic               r_wrap;

    logic               w_adv;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_dir_nxt;
    logic               w_wrap_nxt;
    logic [N_LEDS-1:0]  w_onehot;
    logic [N_LEDS-1:0]  w_light_nxt;

    // Live compare against dwell: lowering dwell below the running count
    // forces an advance on the very next enabled cycle.
    assign w_adv = en && (mode != c_MODE_HOLD) && (r_cnt >= dwell);

    always_comb begin
        w_idx_nxt  = r_idx;
        w_dir_nxt  = r_dir;
        w_wrap_nxt = 1'b0;
        if (w_adv) begin
            if (N_LEDS == 1) begin
                // A single lamp never moves; every step is a full sequence.
                w_wrap_nxt = 1'b1;
            end else begin
                case (mode)
                    c_MODE_FWD: begin
                        if (r_idx == c_IDX_LAST) begin
                            w_idx_nxt  = c_IDX_ZERO;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + c_IDX_ONE;
                        end
                    end
                    c_MODE_REV: begin
                        if (r_idx == c_IDX_ZERO) begin
                            w_idx_nxt  = c_IDX_LAST;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx - c_IDX_ONE;
                        end
                    end
                    c_MODE_PP: begin
                        if (r_dir == c_DIR_UP) begin
                            if (r_idx >= c_IDX_LAST) begin
                                w_dir_nxt = c_DIR_DOWN;
                                w_idx_nxt = c_IDX_LAST - c_IDX_ONE;
                            end else begin
                                w_idx_nxt = r_idx + c_IDX_ONE;
                            end
                        end else begin
                            if (r_idx == c_IDX_ZERO) begin
                                w_dir_nxt  = c_DIR_UP;
                                w_idx_nxt  = c_IDX_ONE;
                                w_wrap_nxt = 1'b1;
                            end else begin
                                w_idx_nxt = r_idx - c_IDX_ONE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Decode the next index so light changes on the same edge as the index.
    for (genvar i = 0; i < N_LEDS; i++) begin : g_onehot
        assign w_onehot[i] = (w_idx_nxt == IDX_W'(i));
    end

`ifdef LED_SEQ_PWM_EN
    logic [3:0] r_pwm_cnt;
    logic       w_pwm_on;

    assign w_pwm_on    = (r_pwm_cnt < duty);
    assign w_light_nxt = w_onehot & {N_LEDS{w_pwm_on}};

    // Free-running brightness counter, deliberately independent of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= 4'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end
`else
    assign w_light_nxt = w_onehot;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= c_IDX_ZERO;
            r_dir   <= c_DIR_UP;
            r_light <= {{(N_LEDS-1){1'b0}}, 1'b1};
            r_step  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            if (en) begin
                if (mode == c_MODE_HOLD || w_adv) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DWELL_W'(1);
                end
            end
            r_idx   <= w_idx_nxt;
            r_dir   <= w_dir_nxt;
            r_light <= w_light_nxt;
            r_step  <= w_adv;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign light = r_light;
    assign step  = r_step;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_led_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_seq
//  Description : Directed self-checking bench for led_seq. Three instances
//                (3, 4 and 1 lamps) share one set of stimulus inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] dwell;

    logic [2:0] light3;
    logic       step3;
    logic       wrap3;
    logic [3:0] light4;
    logic       step4;
    logic       wrap4;
    logic [0:0] light1;
    logic       step1;
    logic       wrap1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_seq #(.N_LEDS(3), .DWELL_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell),
        .light(light3), .step(step3), .wrap(wrap3)
    );

    led_seq #(.N_LEDS(4), .DWELL_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell),
        .light(light4), .step(step4), .wrap(wrap4)
    );

    led_seq #(.N_LEDS(1), .DWELL_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell),
        .light(light1), .step(step1), .wrap(wrap1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [2:0] l, input logic s, input logic w);
        check({tag, ".light3"}, {29'd0, light3}, {29'd0, l});
        check({tag, ".step3"},  {31'd0, step3},  {31'd0, s});
        check({tag, ".wrap3"},  {31'd0, wrap3},  {31'd0, w});
    endtask

    task automatic chk4(input string tag, input logic [3:0] l, input logic s, input logic w);
        check({tag, ".light4"}, {28'd0, light4}, {28'd0, l});
        check({tag, ".step4"},  {31'd0, step4},  {31'd0, s});
        check({tag, ".wrap4"},  {31'd0, wrap4},  {31'd0, w});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        mode  = 2'b00;
        dwell = 8'd0;

        // ---- Reset state
        tick();
        chk3("rst", 3'b001, 1'b0, 1'b0);
        chk4("rst", 4'b0001, 1'b0, 1'b0);
        check("rst.light1", {31'd0, light1}, 32'd1);

        // ---- Forward, dwell 0: a step every cycle
        rst = 1'b0;
        en  = 1'b1;
        tick();
        chk3("fwd1", 3'b010, 1'b1, 1'b0);
        chk4("fwd1", 4'b0010, 1'b1, 1'b0);
        check("fwd1.light1", {31'd0, light1}, 32'd1);
        check("fwd1.step1",  {31'd0, step1},  32'd1);
        check("fwd1.wrap1",  {31'd0, wrap1},  32'd1);
        tick();
        chk3("fwd2", 3'b100, 1'b1, 1'b0);
        chk4("fwd2", 4'b0100, 1'b1, 1'b0);
        tick();
        chk3("fwd3", 3'b001, 1'b1, 1'b1);
        chk4("fwd3", 4'b1000, 1'b1, 1'b0);
        tick();
        chk3("fwd4", 3'b010, 1'b1, 1'b0);
        chk4("fwd4", 4'b0001, 1'b1, 1'b1);

        // ---- Forward, dwell 3, then dwell lowered below the running count
        dwell = 8'd3;
        do_reset();
        tick(); tick(); tick();
        chk3("dw3.wait", 3'b001, 1'b0, 1'b0);
        check("dw3.step1", {31'd0, step1}, 32'd0);
        tick();
        chk3("dw3.adv", 3'b010, 1'b1, 1'b0);
        tick();
        chk3("dw3.after", 3'b010, 1'b0, 1'b0);
        tick();
        dwell = 8'd0;
        tick();
        chk3("dwdrop", 3'b100, 1'b1, 1'b0);

        // ---- Hold clears the count and freezes the index
        dwell = 8'd2;
        tick();
        chk3("pre_hold", 3'b100, 1'b0, 1'b0);
        mode = 2'b11;
        tick(); tick();
        tick();
        chk3("hold", 3'b100, 1'b0, 1'b0);
        mode = 2'b00;
        tick(); tick();
        chk3("hold.cntclr", 3'b100, 1'b0, 1'b0);
        tick();
        chk3("hold.resume", 3'b001, 1'b1, 1'b1);

        // ---- Ping-pong, dwell 0
        mode  = 2'b10;
        dwell = 8'd0;
        do_reset();
        tick();
        chk4("pp1", 4'b0010, 1'b1, 1'b0);
        chk3("pp1", 3'b010, 1'b1, 1'b0);
        tick();
        chk4("pp2", 4'b0100, 1'b1, 1'b0);
        tick();
        chk4("pp3", 4'b1000, 1'b1, 1'b0);
        chk3("pp3", 3'b010, 1'b1, 1'b0);
        tick();
        chk4("pp4", 4'b0100, 1'b1, 1'b0);
        chk3("pp4", 3'b001, 1'b1, 1'b0);
        tick();
        chk4("pp5", 4'b0010, 1'b1, 1'b0);
        chk3("pp5", 3'b010, 1'b1, 1'b1);
        tick();
        chk4("pp6", 4'b0001, 1'b1, 1'b0);
        tick();
        chk4("pp7", 4'b0010, 1'b1, 1'b1);
        check("pp7.wrap1", {31'd0, wrap1}, 32'd1);

        // ---- Reverse from reset, then an en=0 freeze mid-dwell
        mode = 2'b01;
        do_reset();
        tick();
        chk3("rev1", 3'b100, 1'b1, 1'b1);
        tick();
        chk3("rev2", 3'b010, 1'b1, 1'b0);
        tick();
        chk3("rev3", 3'b001, 1'b1, 1'b0);
        dwell = 8'd3;
        tick(); tick();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk3("frozen", 3'b001, 1'b0, 1'b0);
        end
        en = 1'b1;
        tick();
        chk3("resume.wait", 3'b001, 1'b0, 1'b0);
        tick();
        chk3("resume.adv", 3'b100, 1'b1, 1'b1);

        // ---- Reset at index 2 while ping-ponging down (4 lamps)
        mode  = 2'b10;
        dwell = 8'd0;
        do_reset();
        tick(); tick(); tick(); tick();
        chk4("ppdown", 4'b0100, 1'b1, 1'b0);
        dwell = 8'd1;
        rst   = 1'b1;
        tick();
        chk4("midrst", 4'b0001, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk4("midrst.wait", 4'b0001, 1'b0, 1'b0);
        tick();
        chk4("midrst.adv", 4'b0010, 1'b1, 1'b0);
        tick(); tick();
        chk4("midrst.up", 4'b0100, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
